charattr_row_loader: RTL and testbench

Fetches one text row of character/attribute words from main memory and writes them into the 128x32 `charattr_row` buffer, in column order, ahead of the video scan. It sits between the memory arbiter's burst read port and the buffer's write port (`addra`/`cea`/`dia`). A `start` pulse from the video timing generator at each row boundary triggers it.

---
 rtl/charattr_pkg.sv | 14 +
 rtl/charattr_row_loader.sv | 111 +++++++++++
 tb/tb_charattr_row_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/charattr_pkg.sv
// Shared types and sizes for the character/attribute row path.
package charattr_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQUEST = 2'd1,
    S_RECEIVE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam int CHARATTR_W = 32;   // one character/attribute word
  localparam int ROW_DEPTH  = 128;  // charattr_row buffer entries

endpackage

// File: rtl/charattr_row_loader.sv
// Fetches one text row from memory in bursts and streams it, in column
// order, into the charattr_row buffer write port.
module charattr_row_loader
  import charattr_pkg::*;
#(
  parameter int COLUMNS        = 80,
  parameter int ADDR_WIDTH     = 7,
  parameter int MEM_ADDR_WIDTH = 24,
  parameter int BURST          = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] base_address,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_request,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic [4:0]                mem_length,
  input  logic                      mem_ready,
  input  logic                      mem_data_valid,
  input  logic [CHARATTR_W-1:0]     mem_data,
  output logic                      wr_enable,
  output logic [ADDR_WIDTH-1:0]     wr_address,
  output logic [CHARATTR_W-1:0]     wr_data
);

  // Counters must hold 0..COLUMNS inclusive (COLUMNS up to 128).
  localparam int CW = 8;
  localparam logic [CW-1:0] COLS = CW'(COLUMNS);

  state_t                    state;
  logic [MEM_ADDR_WIDTH-1:0] base;
  logic [CW-1:0]             requested;
  logic [CW-1:0]             received;

  // Length of the next burst: a full burst, or whatever is left of the row.
  function automatic logic [4:0] burst_len(input logic [CW-1:0] req);
    logic [CW-1:0] rem;
    rem = COLS - req;
    return (rem > CW'(BURST)) ? 5'(BURST) : rem[4:0];
  endfunction

  // Row-load FSM: one burst outstanding at a time, writes registered one
  // cycle behind each returned beat; stray beats outside RECEIVE are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      base        <= '0;
      requested   <= '0;
      received    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_request <= 1'b0;
      mem_address <= '0;
      mem_length  <= '0;
      wr_enable   <= 1'b0;
      wr_address  <= '0;
      wr_data     <= '0;
    end else begin
      wr_enable <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base        <= base_address;
            requested   <= '0;
            received    <= '0;
            busy        <= 1'b1;
            mem_request <= 1'b1;
            mem_address <= base_address;
            mem_length  <= burst_len('0);
            state       <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (mem_ready) begin
            mem_request <= 1'b0;
            requested   <= requested + CW'(mem_length);
            state       <= S_RECEIVE;
          end
        end
        S_RECEIVE: begin
          if (mem_data_valid) begin
            wr_enable  <= 1'b1;
            wr_address <= ADDR_WIDTH'(received);
            wr_data    <= mem_data;
            received   <= received + CW'(1);
            if (received + CW'(1) == requested) begin
              if (requested < COLS) begin
                mem_request <= 1'b1;
                mem_address <= base + MEM_ADDR_WIDTH'(requested);
                mem_length  <= burst_len(requested);
                state       <= S_REQUEST;
              end else begin
                state <= S_FINISH;
              end
            end
          end
        end
        S_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_charattr_row_loader.sv
// Directed bench: an 80-column loader (stalls, wrap, restarts, reset abort)
// and a 20-column loader (partial last burst, over-long bursts).
module tb_charattr_row_loader;
  import charattr_pkg::*;

  localparam int COLS   = 80;
  localparam int COLS_B = 20;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // 80-column instance
  logic        start, busy, done, mem_request, mem_ready, mem_data_valid, wr_enable;
  logic [23:0] base_address, mem_address;
  logic [4:0]  mem_length;
  logic [31:0] mem_data, wr_data;
  logic [6:0]  wr_address;

  // 20-column instance
  logic        start_b, busy_b, done_b, mem_request_b, mem_ready_b, mem_data_valid_b, wr_enable_b;
  logic [23:0] base_address_b, mem_address_b;
  logic [4:0]  mem_length_b;
  logic [31:0] mem_data_b, wr_data_b;
  logic [6:0]  wr_address_b;

  charattr_row_loader #(.COLUMNS(COLS), .ADDR_WIDTH(7), .MEM_ADDR_WIDTH(24), .BURST(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .base_address(base_address),
    .busy(busy), .done(done), .mem_request(mem_request), .mem_address(mem_address),
    .mem_length(mem_length), .mem_ready(mem_ready), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .wr_enable(wr_enable), .wr_address(wr_address), .wr_data(wr_data));

  charattr_row_loader #(.COLUMNS(COLS_B), .ADDR_WIDTH(7), .MEM_ADDR_WIDTH(24), .BURST(8)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_address(base_address_b),
    .busy(busy_b), .done(done_b), .mem_request(mem_request_b), .mem_address(mem_address_b),
    .mem_length(mem_length_b), .mem_ready(mem_ready_b), .mem_data_valid(mem_data_valid_b),
    .mem_data(mem_data_b), .wr_enable(wr_enable_b), .wr_address(wr_address_b), .wr_data(wr_data_b));

  int nasserts = 0;
  int nfail    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nasserts++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- memory model, 80-column instance ----------------
  int          stall_cyc = 0, gap_cyc = 0;
  bit          stray = 1'b0;
  logic [23:0] bq_addr[$];
  int          bq_len[$];
  int          beats = 0, gapc = 0, waitc = 0, lat_l = 0;
  bit          acc = 1'b0;
  logic [23:0] naddr, lat_a, w_addr;
  logic [4:0]  w_len;

  initial begin
    mem_ready = 1'b0; mem_data_valid = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready = 1'b0; mem_data_valid = 1'b0; beats = 0; acc = 1'b0; waitc = 0;
      end else begin
        if (acc) begin beats = lat_l; naddr = lat_a; gapc = 0; acc = 1'b0; end
        mem_ready = 1'b0;
        if (mem_request && beats == 0) begin
          if (waitc == 0) begin
            w_addr = mem_address; w_len = mem_length;
          end else begin
            check("req_addr_stable", {8'h0, mem_address}, {8'h0, w_addr});
            check("req_len_stable", {27'h0, mem_length}, {27'h0, w_len});
          end
          if (waitc >= stall_cyc) begin
            mem_ready = 1'b1; acc = 1'b1; waitc = 0;
            lat_a = mem_address; lat_l = int'(mem_length);
            bq_addr.push_back(mem_address); bq_len.push_back(int'(mem_length));
          end else waitc++;
        end
        if (beats > 0) begin
          if (gapc == 0) begin
            mem_data_valid = 1'b1; mem_data = {8'h0, naddr};
            naddr = naddr + 24'd1; beats--; gapc = gap_cyc;
          end else begin
            mem_data_valid = 1'b0; gapc--;
          end
        end else begin
          mem_data_valid = stray; mem_data = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- write monitor, 80-column instance ----------------
  int          wcount = 0, dcount = 0;
  logic [23:0] exp_base = '0;
  bit          last_wr = 1'b0;

  initial forever begin
    @(negedge clk);
    if (done) begin
      dcount++;
      check("done_after_last_wr", {31'h0, last_wr}, 32'd1);
      check("busy_low_with_done", {31'h0, busy}, 32'd0);
    end
    if (wr_enable) begin
      check("wr_addr", {25'h0, wr_address}, wcount);
      check("wr_data", wr_data, {8'h0, exp_base + 24'(wcount)});
      last_wr = (wcount == COLS - 1);
      wcount++;
    end else last_wr = 1'b0;
  end

  // ------- memory model, 20-column instance: zero wait, one extra beat -------
  logic [23:0] bq_addr_b[$];
  int          bq_len_b[$];
  int          beats_b = 0, lat_lb = 0;
  bit          acc_b = 1'b0;
  logic [23:0] naddr_b, lat_ab;

  initial begin
    mem_ready_b = 1'b0; mem_data_valid_b = 1'b0; mem_data_b = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready_b = 1'b0; mem_data_valid_b = 1'b0; beats_b = 0; acc_b = 1'b0;
      end else begin
        if (acc_b) begin beats_b = lat_lb + 1; naddr_b = lat_ab; acc_b = 1'b0; end
        mem_ready_b = 1'b0;
        if (mem_request_b && beats_b == 0) begin
          mem_ready_b = 1'b1; acc_b = 1'b1;
          lat_ab = mem_address_b; lat_lb = int'(mem_length_b);
          bq_addr_b.push_back(mem_address_b); bq_len_b.push_back(int'(mem_length_b));
        end
        if (beats_b > 0) begin
          mem_data_valid_b = 1'b1;
          mem_data_b = (beats_b == 1) ? 32'hBAD0_BAD0 : {8'h0, naddr_b};
          naddr_b = naddr_b + 24'd1; beats_b--;
        end else mem_data_valid_b = 1'b0;
      end
    end
  end

  int          wcount_b = 0, dcount_b = 0;
  logic [23:0] exp_base_b = 24'h000500;

  initial forever begin
    @(negedge clk);
    if (done_b) dcount_b++;
    if (wr_enable_b) begin
      check("wr_b_addr", {25'h0, wr_address_b}, wcount_b);
      check("wr_b_data", wr_data_b, {8'h0, exp_base_b + 24'(wcount_b)});
      wcount_b++;
    end
  end

  // ---------------- helpers ----------------
  task automatic load(input logic [23:0] b);
    base_address = b; exp_base = b; wcount = 0; dcount = 0;
    bq_addr.delete(); bq_len.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_t1", {31'h0, busy}, 32'd1);
    check("req_t1", {31'h0, mem_request}, 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && dcount == 0; i++) @(negedge clk);
    check("done_seen", {31'h0, dcount > 0}, 32'd1);
    repeat (3) @(negedge clk);
    check("done_once", dcount, 32'd1);
    check("write_count", wcount, COLS);
  endtask

  task automatic check_bursts(input logic [23:0] b);
    logic [23:0] a;
    check("n_bursts", bq_addr.size(), 32'd10);
    a = b;
    for (int i = 0; i < bq_addr.size(); i++) begin
      check("burst_addr", {8'h0, bq_addr[i]}, {8'h0, a});
      check("burst_len", bq_len[i], 32'd8);
      a = a + 24'd8;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_mem_request", {31'h0, mem_request}, 32'd0);
    check("rst_mem_address", {8'h0, mem_address}, 32'd0);
    check("rst_mem_length", {27'h0, mem_length}, 32'd0);
    check("rst_wr_enable", {31'h0, wr_enable}, 32'd0);
    check("rst_wr_address", {25'h0, wr_address}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start = 1'b0; base_address = '0; start_b = 1'b0; base_address_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // full row zero-wait, with the 20-column partial-burst load alongside
    base_address_b = 24'h000500; start_b = 1'b1;
    load(24'h001000);
    start_b = 1'b0;
    wait_done(2000);
    check_bursts(24'h001000);
    check("b_n_bursts", bq_addr_b.size(), 32'd3);
    check("b_len0", bq_len_b[0], 32'd8);
    check("b_len1", bq_len_b[1], 32'd8);
    check("b_len2", bq_len_b[2], 32'd4);
    check("b_addr2", {8'h0, bq_addr_b[2]}, 32'h000510);
    check("b_writes", wcount_b, 32'd20);
    check("b_done_once", dcount_b, 32'd1);

    // address wrap at the top of memory
    load(24'hFFFFFC);
    wait_done(2000);
    check_bursts(24'hFFFFFC);

    // stalled grant and gapped data
    stall_cyc = 5; gap_cyc = 2;
    load(24'h200000);
    wait_done(4000);
    check_bursts(24'h200000);
    stall_cyc = 0; gap_cyc = 0;

    // start while busy, then stray data in idle
    load(24'h340000);
    repeat (30) @(negedge clk);
    base_address = 24'h777777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2000);
    check_bursts(24'h340000);
    repeat (5) @(negedge clk);
    check("idle_busy", {31'h0, busy}, 32'd0);
    check("idle_req", {31'h0, mem_request}, 32'd0);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_no_write", wcount, COLS);

    // reset mid-load aborts, then a clean reload
    load(24'h050000);
    for (int i = 0; i < 500 && wcount < 37; i++) @(negedge clk);
    check("reached_37", {31'h0, wcount >= 37}, 32'd1);
    reset = 1'b0;
    #1;
    check_reset_outputs();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_no_done", dcount, 32'd0);
    load(24'h060000);
    wait_done(2000);
    check_bursts(24'h060000);

    $display("End of test - %0d assertions evaluated, %0d failures", nasserts, nfail);
    $finish;
  end

endmodule
